// File: rtl/orion_phase_chan_arbiter_pkg.sv
// Shared types and round-robin helpers for the orion 2-phase channel arbiter.
package orion_arb_pkg;

   localparam int MAX_REQ = 16;
   localparam int IDX_W   = 4;

   typedef logic             phase_t;
   typedef logic [IDX_W-1:0] req_idx_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      WAIT_ACK = 2'd2,
      DONE     = 2'd3
   } arb_state_t;

   function automatic req_idx_t rr_next(input req_idx_t idx, input int n);
      return (idx >= req_idx_t'(n - 1)) ? '0 : idx + 1'b1;
   endfunction

   // First set bit at or after ptr, wrapping at n-1; returns ptr when nothing is set.
   function automatic req_idx_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                        input req_idx_t ptr, input int n);
      req_idx_t pick;
      req_idx_t idx;
      logic     found;
      pick  = ptr;
      idx   = ptr;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (i < n && !found && valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
         idx = rr_next(idx, n);
      end
      return pick;
   endfunction

endpackage

// File: rtl/orion_phase_chan_arbiter_if.sv
// Requester and 2-phase channel signals of the orion phase-channel arbiter.
interface orion_phase_chan_arbiter_if
   import orion_arb_pkg::*;
#(
   parameter int N_REQ = 4
);
   localparam int SEL_W = $clog2(N_REQ);

   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_done;
   logic [SEL_W-1:0] out_sel;
   phase_t           out_req;
   phase_t           out_ack;
   logic             busy;
   logic             timeout_err;

   modport master (
      input  req_valid, out_ack,
      output req_done, out_sel, out_req, busy, timeout_err
   );

   modport slave (
      output req_valid, out_ack,
      input  req_done, out_sel, out_req, busy, timeout_err
   );

endinterface

// File: rtl/orion_phase_chan_arbiter_sync_ff.sv
// Multi-stage single-bit synchronizer with a parameterised reset value.
module orion_sync_ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stage_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stage_q <= {STAGES{RST_VAL}};
      end else begin
         stage_q <= {stage_q[STAGES-2:0], d};
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/orion_phase_chan_arbiter.sv
// Round-robin arbiter sharing one 2-phase bundled-data channel among N_REQ requesters.
// Ack watchdog is built only when ORION_PHASE_ARB_TIMEOUT_EN is defined.
module orion_phase_chan_arbiter
   import orion_arb_pkg::*;
#(
   parameter int     N_REQ          = 4,
   parameter int     SYNC_STAGES    = 2,
   parameter phase_t P_INIT         = 1'b0,
   parameter int     TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       reset_n,
   orion_phase_chan_arbiter_if.master bus
);

   // state    | meaning
   // IDLE     | channel free; grant next requester round-robin from rr_ptr
   // SETUP    | out_sel settles one cycle ahead of the req edge
   // WAIT_ACK | req edge issued; wait for synchronized ack phase to match
   // DONE     | one-cycle completion pulse to the owner; advance rr_ptr

   localparam int SEL_W = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > MAX_REQ || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("orion_phase_chan_arbiter: parameter out of range");
   end

   arb_state_t         state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [SEL_W-1:0]   grant_idx;
   phase_t             out_req_q, out_req_d;
   phase_t             ack_sync;
   logic [MAX_REQ-1:0] valid_ext;
   logic [N_REQ-1:0]   done_vec;
   logic               busy_c;

   orion_sync_ff #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (P_INIT)
   ) u_ack_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (bus.out_ack),
      .q       (ack_sync)
   );

   always_comb begin
      valid_ext              = '0;
      valid_ext[N_REQ-1:0]   = bus.req_valid;
   end

   assign grant_idx = SEL_W'(rr_pick(valid_ext, req_idx_t'(rr_ptr_q), N_REQ));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         rr_ptr_q  <= '0;
         out_req_q <= P_INIT;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         rr_ptr_q  <= rr_ptr_d;
         out_req_q <= out_req_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      rr_ptr_d  = rr_ptr_q;
      out_req_d = out_req_q;
      done_vec  = '0;
      busy_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               sel_d   = grant_idx;
               state_d = SETUP;
            end
         end
         SETUP: begin
            busy_c    = 1'b1;
            out_req_d = ~out_req_q;
            state_d   = WAIT_ACK;
         end
         WAIT_ACK: begin
            busy_c = 1'b1;
            // Ack edges seen outside WAIT_ACK only show up here as an early match.
            if (ack_sync == out_req_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_vec[sel_q] = 1'b1;
            rr_ptr_d        = SEL_W'(rr_next(req_idx_t'(sel_q), N_REQ));
            state_d         = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.out_sel  = sel_q;
   assign bus.out_req  = out_req_q;
   assign bus.busy     = busy_c;
   assign bus.req_done = done_vec;

`ifdef ORION_PHASE_ARB_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             tmo_err_q;

   // Loaded on the way into WAIT_ACK; terminal count marks the last allowed cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else if (state_q == SETUP) begin
         tmo_cnt_q <= TMO_W'(TIMEOUT_CYCLES - 1);
      end else if (state_q == WAIT_ACK) begin
         if (tmo_cnt_q == '0) begin
            tmo_err_q <= 1'b1;
         end else begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
         end
      end
   end

   assign bus.timeout_err = tmo_err_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

   a_valid_held : assert property (@(posedge clk) disable iff (!reset_n)
      (state_q == SETUP || state_q == WAIT_ACK) |-> bus.req_valid[sel_q]);

endmodule

// File: tb/tb_orion_phase_chan_arbiter.sv
// Directed bench for orion_phase_chan_arbiter: transfer vector table plus corner-case sequences.
module tb_orion_phase_chan_arbiter;

   localparam int   N_REQ   = 4;
   localparam logic P_INIT  = 1'b1;

   typedef struct {
      logic [3:0] valid;
      int         dly;
      logic [1:0] exp_sel;
      logic [3:0] exp_done;
   } xfer_vec_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_phase;
   xfer_vec_t vecs [12];

   orion_phase_chan_arbiter_if #(.N_REQ(N_REQ)) bus ();

   orion_phase_chan_arbiter #(
      .N_REQ          (N_REQ),
      .SYNC_STAGES    (2),
      .P_INIT         (P_INIT),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One transfer from IDLE; ack echoes out_req dly samples after the req edge.
   task automatic run_xfer(input xfer_vec_t v, input string tag);
      int         done_at;
      int         done_cnt;
      logic [3:0] done_val;
      logic       sel_held;
      logic       busy_ok;
      done_at  = -1;
      done_cnt = 0;
      done_val = '0;
      sel_held = 1'b1;
      busy_ok  = 1'b1;
      chk({tag, "/idle_out_req"}, 32'(bus.out_req), 32'(exp_phase));
      bus.req_valid = v.valid;
      for (int k = 1; k <= 6 + v.dly; k++) begin
         step();
         if (k == 1) begin
            chk({tag, "/sel_at_grant"}, 32'(bus.out_sel), 32'(v.exp_sel));
            chk({tag, "/no_edge_in_setup"}, 32'(bus.out_req), 32'(exp_phase));
         end
         if (k == 2) begin
            exp_phase = ~exp_phase;
            chk({tag, "/req_edge"}, 32'(bus.out_req), 32'(exp_phase));
         end
         if (k == 2 + v.dly) bus.out_ack = exp_phase;
         if (k <= 5 + v.dly && bus.out_sel !== v.exp_sel) sel_held = 1'b0;
         if (k <= 4 + v.dly && bus.busy !== 1'b1) busy_ok = 1'b0;
         if (k == 5 + v.dly) chk({tag, "/busy_in_done"}, 32'(bus.busy), 32'd0);
         if (bus.req_done !== 4'b0000) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at  = k;
               done_val = bus.req_done;
            end
         end
      end
      chk({tag, "/sel_held"}, 32'(sel_held), 32'd1);
      chk({tag, "/busy_held"}, 32'(busy_ok), 32'd1);
      chk({tag, "/done_cycle"}, 32'(done_at), 32'(5 + v.dly));
      chk({tag, "/done_vec"}, 32'(done_val), 32'(v.exp_done));
      chk({tag, "/done_count"}, 32'(done_cnt), 32'd1);
      chk({tag, "/busy_after"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int spur_done;
      int spur_busy;

      // req_valid, ack delay, expected owner, expected done pulse
      vecs[0]  = '{4'b0100, 3, 2'd2, 4'b0100};
      vecs[1]  = '{4'b1000, 1, 2'd3, 4'b1000};
      vecs[2]  = '{4'b1111, 0, 2'd0, 4'b0001};
      vecs[3]  = '{4'b1111, 0, 2'd1, 4'b0010};
      vecs[4]  = '{4'b1111, 2, 2'd2, 4'b0100};
      vecs[5]  = '{4'b1111, 0, 2'd3, 4'b1000};
      vecs[6]  = '{4'b1111, 1, 2'd0, 4'b0001};
      vecs[7]  = '{4'b1001, 0, 2'd3, 4'b1000};
      vecs[8]  = '{4'b1001, 2, 2'd0, 4'b0001};
      vecs[9]  = '{4'b0110, 0, 2'd1, 4'b0010};
      vecs[10] = '{4'b0110, 1, 2'd2, 4'b0100};
      vecs[11] = '{4'b0011, 0, 2'd0, 4'b0001};

      reset_n       = 1'b0;
      bus.req_valid = '0;
      bus.out_ack   = P_INIT;
      exp_phase     = P_INIT;
      repeat (3) step();
      chk("rst/out_req", 32'(bus.out_req), 32'(P_INIT));
      chk("rst/busy", 32'(bus.busy), 32'd0);
      chk("rst/req_done", 32'(bus.req_done), 32'd0);
      chk("rst/out_sel", 32'(bus.out_sel), 32'd0);
      chk("rst/timeout_err", 32'(bus.timeout_err), 32'd0);
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 12; i++) begin
         run_xfer(vecs[i], $sformatf("v%0d", i));
      end

      // Spurious ack edge while idle, then a request that finds the phase already matching.
      bus.req_valid = '0;
      bus.out_ack   = ~exp_phase;
      spur_done     = 0;
      spur_busy     = 0;
      repeat (5) begin
         step();
         if (bus.req_done !== 4'b0000) spur_done++;
         if (bus.busy !== 1'b0) spur_busy++;
      end
      chk("spur/idle_done", 32'(spur_done), 32'd0);
      chk("spur/idle_busy", 32'(spur_busy), 32'd0);
      chk("spur/idle_out_req", 32'(bus.out_req), 32'(exp_phase));
      bus.req_valid = 4'b0010;
      step();
      chk("spur/sel_at_grant", 32'(bus.out_sel), 32'd1);
      step();
      exp_phase = ~exp_phase;
      chk("spur/req_edge", 32'(bus.out_req), 32'(exp_phase));
      chk("spur/sel_wait", 32'(bus.out_sel), 32'd1);
      step();
      chk("spur/early_done", 32'(bus.req_done), 32'b0010);
      chk("spur/sel_done", 32'(bus.out_sel), 32'd1);
      step();
      chk("spur/done_cleared", 32'(bus.req_done), 32'd0);
      chk("spur/busy_after", 32'(bus.busy), 32'd0);

      // Reset in the middle of a transfer (rr_ptr was 2 before the reset).
      bus.req_valid = 4'b0001;
      step();
      step();
      exp_phase = ~exp_phase;
      chk("midrst/req_edge", 32'(bus.out_req), 32'(exp_phase));
      reset_n       = 1'b0;
      bus.req_valid = '0;
      bus.out_ack   = P_INIT;
      exp_phase     = P_INIT;
      repeat (2) step();
      chk("midrst/out_req", 32'(bus.out_req), 32'(P_INIT));
      chk("midrst/busy", 32'(bus.busy), 32'd0);
      chk("midrst/req_done", 32'(bus.req_done), 32'd0);
      reset_n = 1'b1;
      step();
      run_xfer('{4'b0101, 1, 2'd0, 4'b0001}, "post_rst");

      // Ack never returns: requester 2 is granted (rr_ptr is 1).
      bus.req_valid = 4'b0100;
      step();
      chk("tmo/sel", 32'(bus.out_sel), 32'd2);
      step();
      exp_phase = ~exp_phase;
      chk("tmo/req_edge", 32'(bus.out_req), 32'(exp_phase));
`ifdef ORION_PHASE_ARB_TIMEOUT_EN
      for (int k = 3; k <= 17; k++) step();
      chk("tmo/err_before_limit", 32'(bus.timeout_err), 32'd0);
      step();
      chk("tmo/err_set", 32'(bus.timeout_err), 32'd1);
      repeat (6) step();
      chk("tmo/err_sticky", 32'(bus.timeout_err), 32'd1);
      chk("tmo/still_busy", 32'(bus.busy), 32'd1);
`else
      repeat (30) step();
      chk("tmo/err_disabled", 32'(bus.timeout_err), 32'd0);
      chk("tmo/still_busy", 32'(bus.busy), 32'd1);
`endif
      reset_n       = 1'b0;
      bus.req_valid = '0;
      bus.out_ack   = P_INIT;
      exp_phase     = P_INIT;
      repeat (2) step();
      chk("tmo/err_cleared", 32'(bus.timeout_err), 32'd0);
      chk("tmo/out_req_rst", 32'(bus.out_req), 32'(P_INIT));
      chk("tmo/busy_rst", 32'(bus.busy), 32'd0);
      reset_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
